// File: rtl/bit_select_pkg.sv
// Shared types and index mapping for the single-bit selector family.
package bit_select_pkg;

  localparam int unsigned BSEL_IDX_W = 9;

  typedef struct packed {
    logic bit_v;
    logic err;
  } bsel_result_t;

  typedef struct packed {
    logic                  err;
    logic [BSEL_IDX_W-1:0] idx;
  } bsel_map_t;

  typedef enum logic [1:0] {
    SB_EMPTY,
    SB_ONE,
    SB_FULL
  } skid_state_t;

  // Range check happens before mapping so MSB-first can never wrap below zero.
  function automatic bsel_map_t bsel_map(input logic [BSEL_IDX_W-1:0] sel,
                                         input int unsigned width,
                                         input logic msb_first);
    bsel_map_t   r;
    logic [31:0] sel32;
    sel32 = {23'b0, sel};
    r.err = (sel32 >= width);
    if (r.err)          r.idx = '0;
    else if (msb_first) r.idx = BSEL_IDX_W'(width - 32'd1 - sel32);
    else                r.idx = sel;
    return r;
  endfunction

endpackage

// File: rtl/bit_select_pipe_if.sv
// Request/result handshake bundle for bit_select_pipe.
interface bit_select_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned SEL_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  logic             out_err;

  modport master (
    output in_valid, in_sel, in_vec, out_ready,
    input  in_ready, out_valid, out_bit, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_vec, out_ready,
    output in_ready, out_valid, out_bit, out_err
  );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry output/skid register pair; in_ready is registered and never
// depends combinationally on out_ready.
module skid_buffer
  import bit_select_pkg::*;
#(
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o
);

  skid_state_t   state_q;
  logic [DW-1:0] out_q;
  logic [DW-1:0] skid_q;
  logic          out_valid_q;
  logic          in_ready_q;
  logic          accept;
  logic          drain;

  assign accept = in_valid_i && in_ready_q;
  assign drain  = out_valid_q && out_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SB_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (accept) begin
            out_q       <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= SB_ONE;
          end
        end
        SB_ONE: begin
          if (accept && drain) begin
            out_q <= in_data_i;
          end else if (accept) begin
            skid_q     <= in_data_i;
            in_ready_q <= 1'b0;
            state_q    <= SB_FULL;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state_q     <= SB_EMPTY;
          end
        end
        SB_FULL: begin
          if (drain) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= SB_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= SB_EMPTY;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/bit_select_pipe.sv
// Pipelined single-bit selector: combinational index mapping and range check
// at the input, result registered in a 2-entry skid buffer.
module bit_select_pipe
  import bit_select_pkg::*;
#(
  parameter  int unsigned WIDTH     = 16,
  parameter  bit          MSB_FIRST = 1'b1,
  localparam int unsigned SEL_W     = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              reset,
  bit_select_pipe_if.slave bus
);

  bsel_map_t    sel_map;
  bsel_result_t res_d;
  bsel_result_t res_q;

  // One-hot mask select avoids an index narrower than the mapped value.
  always_comb begin
    sel_map   = bsel_map({{(BSEL_IDX_W-SEL_W){1'b0}}, bus.in_sel}, WIDTH, MSB_FIRST);
    res_d     = '0;
    res_d.err = sel_map.err;
    if (!sel_map.err) begin
      res_d.bit_v = |(bus.in_vec & (WIDTH'(1) << sel_map.idx));
    end
  end

  skid_buffer #(
    .DW($bits(bsel_result_t))
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  (res_d),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (res_q)
  );

  assign bus.out_bit = res_q.bit_v;
  assign bus.out_err = res_q.err;

endmodule

// File: tb/tb_bit_select_pipe.sv
// Directed and scoreboard-checked stimulus for bit_select_pipe.
module tb_bit_select_pipe;

  localparam int unsigned NCFG = 8;
  localparam int unsigned NREQ = 1250;
  localparam int unsigned RW [NCFG] = '{2, 2, 16, 16, 37, 37, 256, 256};
  localparam bit          RM [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   go  = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Directed DUTs
  bit_select_pipe_if #(.WIDTH(16)) a_if ();
  bit_select_pipe #(.WIDTH(16), .MSB_FIRST(1'b1)) a_dut (.clk(clk), .reset(rst), .bus(a_if));
  bit_select_pipe_if #(.WIDTH(16)) b_if ();
  bit_select_pipe #(.WIDTH(16), .MSB_FIRST(1'b0)) b_dut (.clk(clk), .reset(rst), .bus(b_if));
  bit_select_pipe_if #(.WIDTH(10)) c_if ();
  bit_select_pipe #(.WIDTH(10), .MSB_FIRST(1'b1)) c_dut (.clk(clk), .reset(rst), .bus(c_if));

  int   a_sel [3] = '{0, 15, 1};
  logic a_bit [3] = '{1'b1, 1'b1, 1'b0};
  int   b_sel [3] = '{2, 13, 0};
  logic b_bit [3] = '{1'b1, 1'b0, 1'b0};
  int   c_sel [3] = '{9, 10, 15};
  logic c_bit [3] = '{1'b1, 1'b0, 1'b0};
  logic c_err [3] = '{1'b0, 1'b1, 1'b1};

  // Randomised configurations, each with its own queue scoreboard
  for (genvar g = 0; g < NCFG; g++) begin : g_rnd
    localparam int unsigned W  = RW[g];
    localparam bit          M  = RM[g];
    localparam int unsigned SW = $clog2(W);

    bit_select_pipe_if #(.WIDTH(W)) r_if ();
    bit_select_pipe #(.WIDTH(W), .MSB_FIRST(M)) r_dut (.clk(clk), .reset(rst), .bus(r_if));

    function automatic logic [1:0] model(input logic [W-1:0] v, input logic [SW-1:0] s);
      int unsigned si;
      si = 32'(s);
      if (si >= W) return 2'b01;
      return {v[M ? (W - 1 - si) : si], 1'b0};
    endfunction

    initial begin
      logic [1:0]  q[$];
      logic [1:0]  exp_r;
      int unsigned sent;
      int unsigned cyc;
      bit          pend;
      r_if.in_valid  = 1'b0;
      r_if.out_ready = 1'b0;
      r_if.in_sel    = '0;
      r_if.in_vec    = '0;
      sent = 0;
      cyc  = 0;
      pend = 1'b0;
      wait (go);
      @(negedge clk);
      while (cyc < 20000 && (sent < NREQ || q.size() != 0)) begin
        if (!pend) begin
          if (sent < NREQ && $urandom_range(9, 0) < 7) begin
            for (int b = 0; b < int'(W); b++) r_if.in_vec[b] = 1'($urandom_range(1, 0));
            r_if.in_sel   = SW'($urandom_range((1 << SW) - 1, 0));
            r_if.in_valid = 1'b1;
            pend          = 1'b1;
          end else begin
            r_if.in_valid = 1'b0;
          end
        end
        r_if.out_ready = (sent >= NREQ) || ($urandom_range(9, 0) < 6);
        if (r_if.out_valid && r_if.out_ready) begin
          if (q.size() == 0) begin
            chk($sformatf("rnd%0d_spurious", g), 32'(r_if.out_valid), 32'd0);
          end else begin
            exp_r = q.pop_front();
            chk($sformatf("rnd%0d_result", g), {30'd0, r_if.out_bit, r_if.out_err}, {30'd0, exp_r});
          end
        end
        if (r_if.in_valid && r_if.in_ready) begin
          q.push_back(model(r_if.in_vec, r_if.in_sel));
          sent++;
          pend = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
      chk($sformatf("rnd%0d_sent", g), sent, NREQ);
      chk($sformatf("rnd%0d_left", g), 32'(q.size()), 32'd0);
      r_if.in_valid  = 1'b0;
      r_if.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("rnd%0d_idle", g), 32'(r_if.out_valid), 32'd0);
      n_done++;
    end
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_sel = '0; a_if.in_vec = '0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_sel = '0; b_if.in_vec = '0; b_if.out_ready = 1'b1;
    c_if.in_valid = 1'b0; c_if.in_sel = '0; c_if.in_vec = '0; c_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_a_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_a_bit",   32'(a_if.out_bit),   32'd0);
    chk("rst_a_err",   32'(a_if.out_err),   32'd0);
    chk("rst_a_ready", 32'(a_if.in_ready),  32'd1);
    chk("rst_b_ready", 32'(b_if.in_ready),  32'd1);
    chk("rst_c_valid", 32'(c_if.out_valid), 32'd0);

    // Streaming, one request per cycle on all three directed DUTs
    a_if.in_vec = 16'h8001;
    b_if.in_vec = 16'h0004;
    c_if.in_vec = 10'h3FF;
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) begin
        chk($sformatf("a_valid%0d", i - 1), 32'(a_if.out_valid), 32'd1);
        chk($sformatf("a_bit%0d", i - 1),   32'(a_if.out_bit),   32'(a_bit[i-1]));
        chk($sformatf("a_err%0d", i - 1),   32'(a_if.out_err),   32'd0);
        chk($sformatf("a_ready%0d", i - 1), 32'(a_if.in_ready),  32'd1);
        chk($sformatf("b_bit%0d", i - 1),   32'(b_if.out_bit),   32'(b_bit[i-1]));
        chk($sformatf("b_err%0d", i - 1),   32'(b_if.out_err),   32'd0);
        chk($sformatf("c_valid%0d", i - 1), 32'(c_if.out_valid), 32'd1);
        chk($sformatf("c_bit%0d", i - 1),   32'(c_if.out_bit),   32'(c_bit[i-1]));
        chk($sformatf("c_err%0d", i - 1),   32'(c_if.out_err),   32'(c_err[i-1]));
      end
      if (i < 3) begin
        a_if.in_sel = 4'(a_sel[i]); a_if.in_valid = 1'b1;
        b_if.in_sel = 4'(b_sel[i]); b_if.in_valid = 1'b1;
        c_if.in_sel = 4'(c_sel[i]); c_if.in_valid = 1'b1;
      end else begin
        a_if.in_valid = 1'b0; b_if.in_valid = 1'b0; c_if.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("stream_a_idle", 32'(a_if.out_valid), 32'd0);
    chk("stream_b_idle", 32'(b_if.out_valid), 32'd0);
    chk("stream_c_idle", 32'(c_if.out_valid), 32'd0);

    // Backpressure: sel 0,1,2 on 16'hA000 MSB-first -> bits 1,0,1
    a_if.out_ready = 1'b0;
    a_if.in_vec    = 16'hA000;
    a_if.in_sel    = 4'd0;
    a_if.in_valid  = 1'b1;
    chk("bp_ready0", 32'(a_if.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_valid1", 32'(a_if.out_valid), 32'd1);
    chk("bp_bit1",   32'(a_if.out_bit),   32'd1);
    chk("bp_ready1", 32'(a_if.in_ready),  32'd1);
    a_if.in_sel = 4'd1;
    @(negedge clk);
    chk("bp_ready2", 32'(a_if.in_ready), 32'd0);
    chk("bp_bit2",   32'(a_if.out_bit),  32'd1);
    a_if.in_sel = 4'd2;
    @(negedge clk);
    chk("bp_ready3", 32'(a_if.in_ready),  32'd0);
    chk("bp_valid3", 32'(a_if.out_valid), 32'd1);
    chk("bp_bit3",   32'(a_if.out_bit),   32'd1);
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_bit4",   32'(a_if.out_bit),  32'd0);
    chk("bp_ready4", 32'(a_if.in_ready), 32'd1);
    @(negedge clk);
    chk("bp_valid5", 32'(a_if.out_valid), 32'd1);
    chk("bp_bit5",   32'(a_if.out_bit),   32'd1);
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_idle", 32'(a_if.out_valid), 32'd0);

    // Reset while FULL, with a request presented during reset
    a_if.out_ready = 1'b0;
    a_if.in_vec    = 16'h4000;
    a_if.in_sel    = 4'd0;
    a_if.in_valid  = 1'b1;
    @(negedge clk);
    a_if.in_sel = 4'd1;
    @(negedge clk);
    chk("full_ready", 32'(a_if.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_if.in_valid = 1'b0;
    chk("rstf_valid", 32'(a_if.out_valid), 32'd0);
    chk("rstf_ready", 32'(a_if.in_ready),  32'd1);
    chk("rstf_bit",   32'(a_if.out_bit),   32'd0);
    a_if.in_sel    = 4'd1;
    a_if.in_valid  = 1'b1;
    a_if.out_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", 32'(a_if.out_valid), 32'd1);
    chk("post_bit",   32'(a_if.out_bit),   32'd1);
    a_if.in_valid = 1'b0;
    @(negedge clk);
    chk("post_idle", 32'(a_if.out_valid), 32'd0);

    go = 1'b1;
    for (int c = 0; c < 40000 && n_done < int'(NCFG); c++) @(negedge clk);
    chk("rnd_done", 32'(n_done), NCFG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_select_pipe.md
# bit_select_pipe

Parametrised, pipelined single-bit selector: picks one bit out of a `WIDTH`-bit vector by index, with a compile-time choice of index direction (MSB-first or LSB-first). It adds a valid/ready handshake, one registered output stage and a 2-entry skid buffer so it can sit between pipeline stages. Out-of-range indices are flagged instead of silently aliasing. It supersedes the fixed 16-way combinational MSB-first selector in CSR/flag-extraction and branch-condition paths.

## Interface
- `WIDTH`, 16, vector width; legal range 2..256, need not be a power of two.
- `MSB_FIRST`, 1, 1: index 0 selects `in_vec[WIDTH-1]`; 0: index 0 selects `in_vec[0]`.
- `SEL_W`, `$clog2(WIDTH)`, index width; derived, never overridden.

- `clk` in 1 — single clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `in_valid` in 1 — request present.
- `in_ready` out 1 — block can accept a request this cycle.
- `in_sel` in SEL_W — bit index.
- `in_vec` in WIDTH — source vector.
- `out_valid` out 1 — result present.
- `out_ready` in 1 — consumer accepts result this cycle.
- `out_bit` out 1 — selected bit.
- `out_err` out 1 — `in_sel` was ≥ `WIDTH`; `out_bit` is 0 in that case.

## Operation
- Request accepted when `in_valid && in_ready`; result delivered when `out_valid && out_ready`.
- Mapped index: `MSB_FIRST` ? `WIDTH-1-in_sel` : `in_sel`, evaluated on unsigned `SEL_W+1`-bit values; no wrap.
- Range check before mapping: `in_sel >= WIDTH` → `out_bit=0`, `out_err=1`. Otherwise `out_err=0`. Only possible when `WIDTH` is not a power of two.
- Result computed combinationally at input, then registered; nothing downstream of the registers is combinational.
- Storage: output register (OUT) plus skid register (SKID), each holding `{valid, bit, err}`.
- States, from OUT/SKID occupancy: EMPTY (neither valid), ONE (OUT valid only), FULL (both valid).
  - EMPTY: accept → ONE.
  - ONE: accept and drain → ONE, OUT takes new result. Accept without drain → FULL, new result into SKID. Drain without accept → EMPTY. Neither → hold.
  - FULL: `in_ready=0`. Drain → ONE, SKID moves to OUT. Otherwise hold.
- `in_ready = !skid_valid`, driven straight from a register and never combinationally from `out_ready`.
- `out_valid = out_valid_q`; `out_bit`/`out_err` come straight from OUT registers.
- Results must stay stable while `out_valid && !out_ready`.
- Ordering is strictly FIFO.

## Timing
- Latency: 1 cycle. A request accepted at edge N shows `out_valid=1` after edge N.
- Throughput: 1 per cycle while `out_ready=1`.
- `in_ready` drops one cycle after the first stalled result. Up to 2 results are buffered.
- Reset values: `out_valid=0`, `out_bit=0`, `out_err=0`, `in_ready=1` in the cycle after `reset` is sampled high. SKID is invalid.
- Reset mid-operation drops all buffered results with no output handshake. Inputs presented during reset are ignored.
- Accept and drain in the same cycle in FULL cannot occur, because `in_ready=0`.

## Structure
- Package `bit_select_pkg`:
  - typedef `bsel_result_t` = packed `{logic bit_v; logic err;}`.
  - function `bsel_map(sel, width, msb_first)` returning `{err, idx}`, so other selectors reuse the same mapping.
- Sub-module `skid_buffer`, parametrised on payload type/width, holds the OUT/SKID logic. `bit_select_pipe` = mapping logic + one `skid_buffer` instance with a 2-bit payload.

## Test plan
- `WIDTH=16, MSB_FIRST=1`, `in_vec=16'h8001`, sel 0 then 15, `out_ready=1` → `out_bit` 1, 1; sel 1 → 0; `out_err=0` throughout; one result per cycle.
- `WIDTH=16, MSB_FIRST=0`, `in_vec=16'h0004`, sel 2 → `out_bit=1`; sel 13 → 0.
- `WIDTH=10, MSB_FIRST=1`, `in_vec=10'h3FF`, sel 9 → bit 1, err 0; sel 10 and 15 → bit 0, err 1.
- Backpressure: `out_ready=0`, offer sel 0,1,2 back-to-back → first two accepted, `in_ready=0` from the 2nd cycle, third held. Raise `out_ready` → results in order 0,1,2, values stable while stalled.
- Reset with FULL buffers → next cycle `out_valid=0`, `in_ready=1`. The following request completes normally with latency 1.
- Random valid/ready toggling over 10k requests against a scoreboard model, across `WIDTH` ∈ {2, 16, 37, 256} × both `MSB_FIRST` values → zero mismatches, no drops or duplicates.
